regfile_dumper: RTL
===================

// Module: regfile_dumper
// PURPOSE
//  Read-side initiator for the 32x64 register file. On a start pulse, walks all 32
//  architectural registers over the two combinational read ports (ra1/ra2 -> rd1/rd2),
//  two registers per fetch. Streams each value with its index over a valid/ready
//  handshake to the debug/trace sink. Sits beside the datapath and shares the read
//  ports only while the core is halted; the top-level muxes ra1/ra2.
// PARAMETERS
//  N       64   register/data width; must match the register file
// PORTS
//  clk        in   1    clock, all state updates on posedge
//  reset      in   1    synchronous, active-high
//  start      in   1    begin dump; sampled only in IDLE
//  ra1        out  5    read address port 1 to regfile (even index of pair)
//  ra2        out  5    read address port 2 to regfile (odd index of pair)
//  rd1        in   N    regfile data for ra1, combinational, same cycle
//  rd2        in   N    regfile data for ra2, combinational, same cycle
//  out_valid  out  1    out_data/out_idx hold a beat
//  out_ready  in   1    sink accepts beat when out_valid & out_ready at posedge
//  out_data   out  N    register value (or checksum)
//  out_idx    out  6    0..31 register index; 32 = checksum beat
//  busy       out  1    dump in progress
//  done       out  1    one-cycle pulse after the final beat is accepted
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, pair=0, ra1=ra2=0, out_valid=0, out_data=0,
//   out_idx=0, busy=0, done=0, buffer cleared. Reset mid-dump aborts: no done pulse,
//   and the beat being transferred is dropped.
//  FSM states:
//   IDLE     ra1=ra2=0. start=1 -> FETCH, pair<=0, busy<=1.
//   FETCH    ra1={pair,0}, ra2={pair,1}. At posedge: capture rd1->buf_lo, rd2->buf_hi,
//            then go to SEND_LO. Exactly one cycle.
//   SEND_LO  out_valid=1, out_data=buf_lo, out_idx=2*pair. On handshake -> SEND_HI.
//   SEND_HI  out_valid=1, out_data=buf_hi, out_idx=2*pair+1. On handshake:
//            if pair<15, then pair<=pair+1 and -> FETCH; else -> FINISH (or CSUM).
//   CSUM     (CSUM build only) out_valid=1, out_data=csum, out_idx=32. On handshake -> FINISH.
//   FINISH   done=1 and busy=0 for this one cycle; then -> IDLE.
//  Handshake: out_data/out_idx hold steady while out_valid & !out_ready. out_valid never
//   drops without a handshake except on reset. out_ready is ignored when out_valid=0.
//  Latency: start at cycle t -> FETCH at t+1 -> first out_valid at t+2. With out_ready
//   held at 1, one pair takes 3 cycles; full dump = 48 cycles + FINISH (+1 with CSUM).
//  busy=1 from the cycle after start up to and including the last beat's handshake cycle.
//  start while busy: ignored. start during FINISH: ignored; a new start is accepted in IDLE.
//  pair counter: 4 bits; increments only on the SEND_HI handshake and never wraps mid-dump.
//  Index 31 (XZR): the value is reported exactly as rd2 returns it (0). No special casing here.
//  Coherency: each pair is a snapshot taken in its FETCH cycle. The dump is not atomic
//   across pairs if the regfile is written during a dump; this is the caller's concern.
// CONFIGURATION
//  DUMPER_CSUM_EN defined: N-bit running XOR of all 32 captured values; csum clears on
//   start and folds buf_lo and buf_hi in at each FETCH capture. An extra beat with idx=32
//   carries it after reg 31, before FINISH.
//  DUMPER_CSUM_EN undefined: no csum register, no CSUM state, FINISH follows reg 31's
//   handshake, and out_idx never exceeds 31.
// TESTING
//  1 Regfile Xi=i (i<31), ready=1, start pulse -> 32 beats idx 0..31, data 0..30 then 0
//    for idx 31; done exactly 1 cycle after idx 31; first valid 2 cycles after start.
//  2 Same stimulus with DUMPER_CSUM_EN -> 33rd beat idx=32, data=64'h1F; then done.
//  3 out_ready toggled 1-0-0-1 pseudo-randomly -> no beat lost/duplicated; data/idx
//    stable throughout every stall.
//  4 start re-pulsed at beats 5 and 20 -> ignored; single 32-beat sequence, one done.
//  5 reset asserted while out_valid=1 at idx 9 -> next cycle all outputs 0, IDLE, no done;
//    a later start produces a full dump from idx 0.
//  6 Regfile write X3<=64'hDEAD issued while the dump sits in SEND_HI of pair 3 ->
//    idx 3 reports 3 (pair 1 was already captured); a second dump reports 64'hDEAD.

Source files
------------

// File: rtl/regfile_dumper_if.sv
// Valid/ready beat stream from the register-file dumper to the debug/trace sink.
// The dumper drives the master side; the sink drives the slave side.
interface regfile_dumper_if #(
  parameter int N = 64
);
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [5:0]   out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/regfile_dumper.sv
// Walks all 32 registers two at a time over the regfile read ports and streams them out.
// Define DUMPER_CSUM_EN to append an XOR checksum beat (idx 32) after register 31.
module regfile_dumper #(
  parameter int N = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [4:0]              ra1,
  output logic [4:0]              ra2,
  input  logic [N-1:0]            rd1,
  input  logic [N-1:0]            rd2,
  regfile_dumper_if.master        stream,
  output logic                    busy,
  output logic                    done
);

`ifdef DUMPER_CSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND_LO, SEND_HI, CSUM, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SEND_LO, SEND_HI, FINISH} state_t;
`endif

  state_t       state_reg, state_next;
  logic [3:0]   pair_reg, pair_next;
  logic [N-1:0] buf_lo_reg, buf_hi_reg;
  logic         valid;
  logic [N-1:0] data;
  logic [5:0]   idx;

`ifdef DUMPER_CSUM_EN
  logic [N-1:0] csum_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      pair_reg   <= '0;
      buf_lo_reg <= '0;
      buf_hi_reg <= '0;
    end else begin
      state_reg <= state_next;
      pair_reg  <= pair_next;
      // Each pair is a snapshot of the regfile taken in its single FETCH cycle.
      if (state_reg == FETCH) begin
        buf_lo_reg <= rd1;
        buf_hi_reg <= rd2;
      end
    end
  end

`ifdef DUMPER_CSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      csum_reg <= '0;
    end else if (state_reg == FETCH) begin
      csum_reg <= csum_reg ^ rd1 ^ rd2;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    pair_next  = pair_reg;
    ra1        = '0;
    ra2        = '0;
    valid      = 1'b0;
    data       = '0;
    idx        = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = FETCH;
          pair_next  = '0;
        end
      end
      FETCH: begin
        ra1        = {pair_reg, 1'b0};
        ra2        = {pair_reg, 1'b1};
        state_next = SEND_LO;
      end
      SEND_LO: begin
        valid = 1'b1;
        data  = buf_lo_reg;
        idx   = {1'b0, pair_reg, 1'b0};
        if (stream.out_ready) state_next = SEND_HI;
      end
      SEND_HI: begin
        valid = 1'b1;
        data  = buf_hi_reg;
        idx   = {1'b0, pair_reg, 1'b1};
        if (stream.out_ready) begin
          if (pair_reg != 4'd15) begin
            pair_next  = pair_reg + 4'd1;
            state_next = FETCH;
          end else begin
`ifdef DUMPER_CSUM_EN
            state_next = CSUM;
`else
            state_next = FINISH;
`endif
          end
        end
      end
`ifdef DUMPER_CSUM_EN
      CSUM: begin
        valid = 1'b1;
        data  = csum_reg;
        idx   = 6'd32;
        if (stream.out_ready) state_next = FINISH;
      end
`endif
      FINISH: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign stream.out_valid = valid;
  assign stream.out_data  = data;
  assign stream.out_idx   = idx;

endmodule
